// File: rtl/axi_table_mem_if.sv
// AXI4 bus bundle between the packet processor's AXI bridge and the
// match/action table memory. The slave modport is the memory side.
interface axi_table_mem_if;
    // Write address channel
    logic        axi_awid;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awlock;
    logic [3:0]  axi_awcache;
    logic [2:0]  axi_awprot;
    logic [3:0]  axi_awqos;
    logic        axi_awvalid;
    logic        axi_awready;
    // Write data channel
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_wvalid;
    logic        axi_wready;
    // Write response channel
    logic        axi_bid;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    // Read address channel
    logic        axi_arid;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arlock;
    logic [3:0]  axi_arcache;
    logic [2:0]  axi_arprot;
    logic [3:0]  axi_arqos;
    logic        axi_arvalid;
    logic        axi_arready;
    // Read data channel
    logic        axi_rid;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rvalid;
    logic        axi_rready;

    modport slave (
        input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
               axi_awlock, axi_awcache, axi_awprot, axi_awqos, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bid, axi_bresp, axi_bvalid,
        input  axi_bready,
        input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
               axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arvalid,
        output axi_arready,
        output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        input  axi_rready
    );

    modport master (
        output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
               axi_awlock, axi_awcache, axi_awprot, axi_awqos, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bid, axi_bresp, axi_bvalid,
        output axi_bready,
        output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
               axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arvalid,
        input  axi_arready,
        input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
        output axi_rready
    );
endinterface

// File: rtl/axi_table_mem.sv
// AXI4 slave word memory holding the packet processor's match-table and
// action words. Independent write and read state machines share one 32-bit
// word array; single beats and INCR/FIXED bursts (WRAP handled as INCR).
// Every bus output comes straight from a flop.
module axi_table_mem #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    axi_table_mem_if.slave   axi
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} r_state_t;

    // A beat misses the array when its address is below the base or its
    // word index lands past the last word.
    function automatic logic beat_oor(input logic below, input logic [29:0] idx);
        return below | ((idx >> ADDR_WIDTH) != 30'd0);
    endfunction

    logic [31:0] mem_r [DEPTH];

    // Address decode: borrow of the 33-bit subtraction flags "below base".
    logic [32:0] aw_diff_s;
    logic [32:0] ar_diff_s;
    assign aw_diff_s = {1'b0, axi.axi_awaddr} - {1'b0, BASE_ADDR};
    assign ar_diff_s = {1'b0, axi.axi_araddr} - {1'b0, BASE_ADDR};

    // Fields the memory deliberately ignores (size fixed to 32 bits,
    // no locking/caching/protection/QoS, byte offset dropped).
    logic unused_s;
    assign unused_s = ^{axi.axi_awsize, axi.axi_awlock, axi.axi_awcache, axi.axi_awprot,
                        axi.axi_awqos, axi.axi_arsize, axi.axi_arlock, axi.axi_arcache,
                        axi.axi_arprot, axi.axi_arqos, aw_diff_s[1:0], ar_diff_s[1:0]};

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    w_state_t    w_state_r, w_next_s;
    logic        awready_r, wready_r, bvalid_r, bid_r;
    logic [1:0]  bresp_r;
    logic        wid_r, wbelow_r, wfixed_r, werr_r;
    logic [29:0] widx_r;
    logic [7:0]  wlen_r, wbeat_r;
    logic        aw_fire_s, w_fire_s, w_last_s, w_oor_s, w_err_next_s;

    assign aw_fire_s = (w_state_r == W_IDLE) && awready_r && axi.axi_awvalid;
    assign w_fire_s  = (w_state_r == W_DATA) && wready_r && axi.axi_wvalid;
    assign w_last_s  = (wbeat_r == wlen_r);
    assign w_oor_s   = beat_oor(wbelow_r, widx_r);

    // Write FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_r <= W_IDLE;
        end else begin
            w_state_r <= w_next_s;
        end
    end

    // Write FSM next state; the beat counter, not wlast, ends the burst.
    always_comb begin
        w_next_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (aw_fire_s) w_next_s = W_DATA;
                else           w_next_s = W_IDLE;
            end
            W_DATA: begin
                if (w_fire_s && w_last_s) w_next_s = W_RESP;
                else                      w_next_s = W_DATA;
            end
            W_RESP: begin
                if (axi.axi_bready) w_next_s = W_IDLE;
                else                w_next_s = W_RESP;
            end
            default: w_next_s = W_IDLE;
        endcase
    end

    // Sticky burst error: any dropped beat or a wlast that disagrees with the count.
    always_comb begin
        w_err_next_s = werr_r;
        if (w_fire_s) begin
            w_err_next_s = werr_r | w_oor_s | (axi.axi_wlast != w_last_s);
        end else begin
            w_err_next_s = werr_r;
        end
    end

    // Write request capture and per-beat index/counter advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wid_r    <= 1'b0;
            wbelow_r <= 1'b0;
            wfixed_r <= 1'b0;
            widx_r   <= 30'd0;
            wlen_r   <= 8'd0;
            wbeat_r  <= 8'd0;
            werr_r   <= 1'b0;
        end else if (aw_fire_s) begin
            wid_r    <= axi.axi_awid;
            wbelow_r <= aw_diff_s[32];
            wfixed_r <= (axi.axi_awburst == 2'b00);
            widx_r   <= aw_diff_s[31:2];
            wlen_r   <= axi.axi_awlen;
            wbeat_r  <= 8'd0;
            werr_r   <= 1'b0;
        end else if (w_fire_s) begin
            werr_r <= w_err_next_s;
            if (!w_last_s) begin
                wbeat_r <= wbeat_r + 8'd1;
                if (!wfixed_r) widx_r <= widx_r + 30'd1;
            end
        end
    end

    // Write channel outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bid_r     <= 1'b0;
            bresp_r   <= 2'b00;
        end else begin
            awready_r <= (w_next_s == W_IDLE);
            wready_r  <= (w_next_s == W_DATA);
            bvalid_r  <= (w_next_s == W_RESP);
            bid_r     <= (w_next_s == W_RESP) ? wid_r : 1'b0;
            bresp_r   <= (w_next_s == W_RESP) ? {w_err_next_s, 1'b0} : 2'b00;
        end
    end

    // Byte-strobed array write; out-of-range beats never touch the array.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_fire_s && !w_oor_s && axi.axi_wstrb[b]) begin
                mem_r[widx_r[ADDR_WIDTH-1:0]][8*b +: 8] <= axi.axi_wdata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    r_state_t    r_state_r, r_next_s;
    logic        arready_r, rvalid_r, rid_r, rlast_r;
    logic [1:0]  rresp_r;
    logic [31:0] rdata_r;
    logic        arid_r, rbelow_r, rfixed_r;
    logic [29:0] ridx_r;
    logic [7:0]  rlen_r, rbeat_r;
    logic        ar_fire_s, r_fire_s, r_last_s, r_oor_s;

    assign ar_fire_s = (r_state_r == R_IDLE) && arready_r && axi.axi_arvalid;
    assign r_fire_s  = (r_state_r == R_DATA) && rvalid_r && axi.axi_rready;
    assign r_last_s  = (rbeat_r == rlen_r);
    assign r_oor_s   = beat_oor(rbelow_r, ridx_r);

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_r <= R_IDLE;
        end else begin
            r_state_r <= r_next_s;
        end
    end

    // Read FSM next state: fetch one word, present it, repeat until the last beat.
    always_comb begin
        r_next_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_fire_s) r_next_s = R_FETCH;
                else           r_next_s = R_IDLE;
            end
            R_FETCH: r_next_s = R_DATA;
            R_DATA: begin
                if (r_fire_s) r_next_s = r_last_s ? R_IDLE : R_FETCH;
                else          r_next_s = R_DATA;
            end
            default: r_next_s = R_IDLE;
        endcase
    end

    // Read request capture and per-beat index/counter advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arid_r   <= 1'b0;
            rbelow_r <= 1'b0;
            rfixed_r <= 1'b0;
            ridx_r   <= 30'd0;
            rlen_r   <= 8'd0;
            rbeat_r  <= 8'd0;
        end else if (ar_fire_s) begin
            arid_r   <= axi.axi_arid;
            rbelow_r <= ar_diff_s[32];
            rfixed_r <= (axi.axi_arburst == 2'b00);
            ridx_r   <= ar_diff_s[31:2];
            rlen_r   <= axi.axi_arlen;
            rbeat_r  <= 8'd0;
        end else if (r_fire_s && !r_last_s) begin
            rbeat_r <= rbeat_r + 8'd1;
            if (!rfixed_r) ridx_r <= ridx_r + 30'd1;
        end
    end

    // Read channel outputs; the beat is loaded from the array in R_FETCH and
    // held until its handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rid_r     <= 1'b0;
            rdata_r   <= 32'd0;
            rresp_r   <= 2'b00;
            rlast_r   <= 1'b0;
        end else begin
            arready_r <= (r_next_s == R_IDLE);
            rvalid_r  <= (r_next_s == R_DATA);
            if (r_state_r == R_FETCH) begin
                rid_r   <= arid_r;
                rdata_r <= r_oor_s ? 32'd0 : mem_r[ridx_r[ADDR_WIDTH-1:0]];
                rresp_r <= r_oor_s ? 2'b10 : 2'b00;
                rlast_r <= r_last_s;
            end else if (r_next_s != R_DATA) begin
                rid_r   <= 1'b0;
                rdata_r <= 32'd0;
                rresp_r <= 2'b00;
                rlast_r <= 1'b0;
            end else begin
                rid_r   <= rid_r;
                rdata_r <= rdata_r;
                rresp_r <= rresp_r;
                rlast_r <= rlast_r;
            end
        end
    end

    assign axi.axi_awready = awready_r;
    assign axi.axi_wready  = wready_r;
    assign axi.axi_bvalid  = bvalid_r;
    assign axi.axi_bid     = bid_r;
    assign axi.axi_bresp   = bresp_r;
    assign axi.axi_arready = arready_r;
    assign axi.axi_rvalid  = rvalid_r;
    assign axi.axi_rid     = rid_r;
    assign axi.axi_rdata   = rdata_r;
    assign axi.axi_rresp   = rresp_r;
    assign axi.axi_rlast   = rlast_r;

endmodule
